// File: rtl/vector_diff_ctrl.sv
// Requester-side controller for the 4-lane max-abs-difference unit: assembles
// samples into vectors, issues one compare per new vector, returns a flagged result.
module vector_diff_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_lane,
  input  logic [WIDTH-1:0]   thresh,
  output logic               start,
  output logic [4*WIDTH-1:0] vec_new,
  output logic [4*WIDTH-1:0] vec_old,
  input  logic               done,
  input  logic [WIDTH-1:0]   max_diff,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_max,
  output logic               res_motion,
  output logic               res_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {FILL, START, WAIT, RESULT} state_e;

  state_e             state_q, state_d;
  logic [1:0]         lane_q, lane_d;
  logic               primed_q, primed_d;
  logic [CW-1:0]      tmo_q, tmo_d;
  logic [4*WIDTH-1:0] vec_new_q, vec_new_d;
  logic [4*WIDTH-1:0] vec_old_q, vec_old_d;
  logic [WIDTH-1:0]   res_max_q, res_max_d;
  logic               res_motion_q, res_motion_d;
  logic               res_err_q, res_err_d;

  // Gate with reset so in_ready stays low while reset is held.
  assign in_ready   = reset && (state_q == FILL);
  assign start      = (state_q == START);
  assign res_valid  = (state_q == RESULT);
  assign vec_new    = vec_new_q;
  assign vec_old    = vec_old_q;
  assign res_max    = res_max_q;
  assign res_motion = res_motion_q;
  assign res_err    = res_err_q;

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    primed_d     = primed_q;
    tmo_d        = tmo_q;
    vec_new_d    = vec_new_q;
    vec_old_d    = vec_old_q;
    res_max_d    = res_max_q;
    res_motion_d = res_motion_q;
    res_err_d    = res_err_q;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          vec_new_d[lane_q*WIDTH +: WIDTH] = in_lane;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            // The very first vector only becomes the reference.
            if (!primed_q) begin
              vec_old_d = vec_new_d;
              primed_d  = 1'b1;
            end else begin
              state_d = START;
            end
          end
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmo_d = tmo_q + CW'(1);
        if (done) begin
          res_max_d    = max_diff;
          res_motion_d = (max_diff > thresh);
          res_err_d    = 1'b0;
          state_d      = RESULT;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          res_max_d    = '0;
          res_motion_d = 1'b0;
          res_err_d    = 1'b1;
          state_d      = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          vec_old_d = vec_new_q;
          lane_d    = 2'd0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FILL;
      lane_q       <= 2'd0;
      primed_q     <= 1'b0;
      tmo_q        <= '0;
      vec_new_q    <= '0;
      vec_old_q    <= '0;
      res_max_q    <= '0;
      res_motion_q <= 1'b0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      primed_q     <= primed_d;
      tmo_q        <= tmo_d;
      vec_new_q    <= vec_new_d;
      vec_old_q    <= vec_old_d;
      res_max_q    <= res_max_d;
      res_motion_q <= res_motion_d;
      res_err_q    <= res_err_d;
    end
  end

endmodule

// File: tb/tb_vector_diff_ctrl.sv
// Bench for vector_diff_ctrl: directed scenarios plus random vectors, against a
// vector-level reference model and a behavioural diff-unit peer.
module tb_vector_diff_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [3:0]  in_lane, thresh;
  logic        start;
  logic [15:0] vec_new, vec_old;
  logic        done;
  logic [3:0]  max_diff;
  logic        res_valid, res_ready;
  logic [3:0]  res_max;
  logic        res_motion, res_err;

  int n_cmp = 0;
  int n_err = 0;

  bit          stub_en;
  logic [2:0]  scnt;
  bit          m_primed;
  logic [15:0] m_old;

  vector_diff_ctrl #(.WIDTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane(in_lane), .thresh(thresh), .start(start), .vec_new(vec_new),
    .vec_old(vec_old), .done(done), .max_diff(max_diff), .res_valid(res_valid),
    .res_ready(res_ready), .res_max(res_max), .res_motion(res_motion),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_diff(input logic [15:0] a, input logic [15:0] b);
    int m = 0;
    for (int i = 0; i < 4; i++) begin
      int x = int'(a[i*4 +: 4]);
      int y = int'(b[i*4 +: 4]);
      int d = (x > y) ? x - y : y - x;
      if (d > m) m = d;
    end
    return 4'(m);
  endfunction

  // Diff-unit peer: done rises 5 cycles after start and stays high until the
  // cycle after the next start.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt <= 3'd0; done <= 1'b0; max_diff <= 4'd0;
    end else if (start) begin
      scnt <= 3'd1; done <= 1'b0;
    end else if (scnt != 3'd0 && scnt < 3'd4) begin
      scnt <= scnt + 3'd1;
    end else if (scnt == 3'd4) begin
      scnt <= 3'd0;
      if (stub_en) begin
        done <= 1'b1; max_diff <= ref_diff(vec_new, vec_old);
      end else begin
        max_diff <= 4'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] v);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 1)) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1;
      in_lane  = v[k*4 +: 4];
      chk("in_ready_fill", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] v, input int hold);
    int lat, extra;
    logic [3:0] em; logic emot, eerr;
    feed(v);
    if (!m_primed) begin
      chk("start_prime", 32'(start), 32'd0);
      chk("vec_old_prime", 32'(vec_old), 32'(v));
      chk("in_ready_prime", 32'(in_ready), 32'd1);
      chk("res_valid_prime", 32'(res_valid), 32'd0);
      m_primed = 1'b1;
      m_old    = v;
      return;
    end
    chk("start", 32'(start), 32'd1);
    chk("vec_new", 32'(vec_new), 32'(v));
    chk("vec_old", 32'(vec_old), 32'(m_old));
    chk("in_ready_start", 32'(in_ready), 32'd0);
    lat = 0; extra = 0;
    while (!res_valid && lat < 40) begin
      tick(); lat++;
      if (start) extra++;
      chk("vec_new_wait", 32'(vec_new), 32'(v));
    end
    chk("start_once", 32'(extra), 32'd0);
    chk("latency", 32'(lat), stub_en ? 32'd6 : 32'(TIMEOUT + 1));
    if (stub_en) begin
      em = ref_diff(v, m_old); emot = (em > thresh); eerr = 1'b0;
    end else begin
      em = 4'd0; emot = 1'b0; eerr = 1'b1;
    end
    chk("res_max", 32'(res_max), 32'(em));
    chk("res_motion", 32'(res_motion), 32'(emot));
    chk("res_err", 32'(res_err), 32'(eerr));
    in_valid = 1'b1; in_lane = 4'($urandom); res_ready = 1'b0;
    repeat (hold) begin
      tick();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_max", 32'(res_max), 32'(em));
      chk("hold_motion", 32'(res_motion), 32'(emot));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("post_accept_valid", 32'(res_valid), 32'd0);
    chk("post_accept_in_ready", 32'(in_ready), 32'd1);
    m_old = v;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_lane = 4'd0; thresh = 4'd0;
    res_ready = 1'b0; stub_en = 1'b1; m_primed = 1'b0; m_old = 16'd0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_vecs", 32'({vec_new, vec_old}), 32'd0);
    chk("rst_res", 32'({res_max, res_motion, res_err}), 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    send_vec(16'h4321, 0);
    thresh = 4'd4; send_vec(16'h9325, 0);
    thresh = 4'd5; send_vec(16'h9320, 0);
    thresh = 4'd3; send_vec(16'h1234, 10);
    stub_en = 1'b0; send_vec(16'h5A5A, 2);
    stub_en = 1'b1;

    // Reset in the middle of a compare.
    feed(16'h7777);
    chk("mid_start", 32'(start), 32'd1);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({start, res_valid, in_ready, res_max, res_motion, res_err}), 32'd0);
    chk("mid_rst_vecs", 32'({vec_new, vec_old}), 32'd0);
    tick();
    reset = 1'b1;
    m_primed = 1'b0; m_old = 16'd0;
    tick();

    thresh = 4'hE;
    send_vec(16'h0000, 0);
    send_vec(16'hF0A3, 1);
    send_vec(16'hF0A3, 0);

    for (int i = 0; i < 25; i++) begin
      thresh  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
      stub_en = ($urandom_range(0, 5) != 0);
      send_vec(16'($urandom), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
